// File: rtl/rv_imem_pkg.sv
// Shared types and helpers for the instruction-fetch responder.
package rv_imem_pkg;

  typedef enum logic {
    IMEM_IDLE = 1'b0,
    IMEM_WAIT = 1'b1
  } imem_state_e;

  // Default word for out-of-range fetches; all-zero decodes as illegal.
  localparam logic [31:0] IMEM_OOR_DEFAULT = 32'h0000_0000;

  localparam int unsigned IMEM_CNT_BITS = 4;

  // Address is passed zero-extended, so any bit above the SRAM word index
  // marks it out of range; when the bus is no wider than the index the shift
  // leaves only zeros and the check folds away.
  function automatic logic imem_out_of_range(input logic [63:0] addr,
                                             input int unsigned word_bits);
    return (addr >> (word_bits + 2)) != '0;
  endfunction

endpackage

// File: rtl/rv_imem_hitbuf.sv
// One-word instruction hit buffer: tag/data/valid register with tag compare.
module rv_imem_hitbuf
  import rv_imem_pkg::*;
#(
  parameter int unsigned TAG_W  = 14,
  parameter bit          ENABLE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  output logic [31:0]      data_o,
  input  logic             wr_en_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_data_i,
  input  logic             inv_i
);

  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;

  // Fill on returning SRAM data, drop on an out-of-range response.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en_i) begin
      valid_d = 1'b1;
      tag_d   = wr_tag_i;
      data_d  = wr_data_i;
    end else if (inv_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = ENABLE && valid_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/rv_imem_resp.sv
// Instruction-fetch responder in front of a 1-cycle-latency SRAM macro,
// with optional wait states and a one-word hit buffer.
module rv_imem_resp
  import rv_imem_pkg::*;
#(
  parameter int unsigned IADDR_SPACE_BITS = 16,
  parameter int unsigned MEM_WORDS_BITS   = 12,
  parameter int unsigned WAIT_STATES      = 0,
  parameter bit          HIT_BUFFER       = 1'b1,
  parameter logic [31:0] OOR_INSTR        = IMEM_OOR_DEFAULT
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_cyc,
  input  logic [IADDR_SPACE_BITS-1:0] i_addr,
  output logic                        o_ack,
  output logic [31:0]                 o_instruction,
  output logic [MEM_WORDS_BITS-1:0]   o_mem_addr,
  output logic                        o_mem_re,
  input  logic [31:0]                 i_mem_rdata,
  output logic                        o_busy
);

  localparam int unsigned TAG_W = IADDR_SPACE_BITS - 2;
  localparam bit          NO_WAIT = (WAIT_STATES == 0);
  localparam logic [IMEM_CNT_BITS-1:0] CNT_START = IMEM_CNT_BITS'(WAIT_STATES - 1);

  if (WAIT_STATES > 15) begin : g_ws_range
    $error("rv_imem_resp: WAIT_STATES must be within 0..15");
  end

  imem_state_e              state_q, state_d;
  logic [IMEM_CNT_BITS-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]         wait_tag_q, wait_tag_d;

  logic                     sram_pend_q, oor_pend_q;
  logic [TAG_W-1:0]         pend_tag_q;
  logic [31:0]              instr_q;

  logic [63:0]              addr_ext;
  logic [TAG_W-1:0]         req_tag;
  logic                     req_oor;
  logic                     req;
  logic                     hit;
  logic [31:0]              hit_data;
  logic                     ack, mem_re, busy, ack_hit, ack_oor;

  assign addr_ext   = 64'(i_addr);
  assign req_tag    = i_addr[IADDR_SPACE_BITS-1:2];
  assign req_oor    = imem_out_of_range(addr_ext, MEM_WORDS_BITS);
  // Gating with reset keeps ack/read low while reset is held, even with a
  // zero-wait configuration whose IDLE ack is purely combinational.
  assign req        = i_cyc & i_reset_n;
  assign o_mem_addr = addr_ext[MEM_WORDS_BITS+1:2];

  rv_imem_hitbuf #(
    .TAG_W  (TAG_W),
    .ENABLE (HIT_BUFFER)
  ) u_hitbuf (
    .clk_i        (i_clk),
    .rst_ni       (i_reset_n),
    .lookup_tag_i (req_tag),
    .hit_o        (hit),
    .data_o       (hit_data),
    .wr_en_i      (sram_pend_q),
    .wr_tag_i     (pend_tag_q),
    .wr_data_i    (i_mem_rdata),
    .inv_i        (oor_pend_q)
  );

  // FSM state and wait counter registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IMEM_IDLE;
      cnt_q      <= '0;
      wait_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_tag_q <= wait_tag_d;
    end
  end

  // Next state: enter WAIT on a slow miss, leave on abort/redirect or expiry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_tag_d = wait_tag_q;
    unique case (state_q)
      IMEM_IDLE: begin
        if (req && !(hit || req_oor || NO_WAIT)) begin
          state_d    = IMEM_WAIT;
          cnt_d      = CNT_START;
          wait_tag_d = req_tag;
        end
      end
      IMEM_WAIT: begin
        if (!req || (req_tag != wait_tag_q)) begin
          state_d = IMEM_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IMEM_IDLE;
        end
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  // Outputs: ack, SRAM read strobe and the kind of response being launched.
  always_comb begin
    ack     = 1'b0;
    mem_re  = 1'b0;
    busy    = 1'b0;
    ack_hit = 1'b0;
    ack_oor = 1'b0;
    unique case (state_q)
      IMEM_IDLE: begin
        if (req && (hit || req_oor || NO_WAIT)) begin
          ack     = 1'b1;
          ack_hit = hit;
          ack_oor = !hit && req_oor;
          mem_re  = !hit && !req_oor;
        end
      end
      IMEM_WAIT: begin
        busy = i_reset_n;
        if (req && (req_tag == wait_tag_q) && (cnt_q == '0)) begin
          ack     = 1'b1;
          ack_oor = req_oor;
          mem_re  = !req_oor;
        end
      end
      default: ;
    endcase
  end

  // Response pipeline: SRAM data bypasses straight out in the cycle it
  // arrives and is captured for holding; hit/OOR words are captured at ack
  // time because the buffer may be rewritten on that same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sram_pend_q <= 1'b0;
      oor_pend_q  <= 1'b0;
      pend_tag_q  <= '0;
      instr_q     <= OOR_INSTR;
    end else begin
      sram_pend_q <= mem_re;
      oor_pend_q  <= ack_oor;
      if (mem_re) begin
        pend_tag_q <= req_tag;
      end
      if (ack_hit) begin
        instr_q <= hit_data;
      end else if (ack_oor) begin
        instr_q <= OOR_INSTR;
      end else if (sram_pend_q) begin
        instr_q <= i_mem_rdata;
      end
    end
  end

  assign o_ack         = ack;
  assign o_mem_re      = mem_re;
  assign o_busy        = busy;
  assign o_instruction = sram_pend_q ? i_mem_rdata : instr_q;

endmodule

// File: tb/tb_rv_imem_resp.sv
// Randomized bench for rv_imem_resp: two configurations share one stimulus
// stream and are each checked every cycle against a cycle-level reference.
module tb_rv_imem_resp;

  localparam int unsigned AW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc;
  logic [15:0] addr;

  logic        ack0, re0, busy0, ack1, re1, busy1;
  logic [31:0] instr0, instr1, rdata0, rdata1;
  logic [3:0]  maddr0;
  logic [7:0]  maddr1;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ w;
  endfunction

  // zero-wait, 16-word memory
  rv_imem_resp #(
    .IADDR_SPACE_BITS (AW),
    .MEM_WORDS_BITS   (4),
    .WAIT_STATES      (0),
    .HIT_BUFFER       (1'b1),
    .OOR_INSTR        (32'h0000_0000)
  ) dut0 (
    .i_clk (clk), .i_reset_n (rst_n), .i_cyc (cyc), .i_addr (addr),
    .o_ack (ack0), .o_instruction (instr0), .o_mem_addr (maddr0),
    .o_mem_re (re0), .i_mem_rdata (rdata0), .o_busy (busy0)
  );

  // three wait states, 256-word memory
  rv_imem_resp #(
    .IADDR_SPACE_BITS (AW),
    .MEM_WORDS_BITS   (8),
    .WAIT_STATES      (3),
    .HIT_BUFFER       (1'b1),
    .OOR_INSTR        (32'h0000_0000)
  ) dut1 (
    .i_clk (clk), .i_reset_n (rst_n), .i_cyc (cyc), .i_addr (addr),
    .o_ack (ack1), .o_instruction (instr1), .o_mem_addr (maddr1),
    .o_mem_re (re1), .i_mem_rdata (rdata1), .o_busy (busy1)
  );

  // SRAM macros: 1-cycle read latency, output holds between reads
  always @(posedge clk) if (re0) rdata0 <= memfn(32'(maddr0));
  always @(posedge clk) if (re1) rdata1 <= memfn(32'(maddr1));

  // reference model state, one slot per DUT
  int unsigned ws[2] = '{0, 3};
  int unsigned mw[2] = '{4, 8};
  bit          m_att[2];      // a slow miss is being waited out
  int unsigned m_att_tag[2];
  int unsigned m_elapsed[2];  // cycles held since the miss started
  bit          m_bv[2];
  int unsigned m_btag[2];
  int unsigned m_pend[2];     // response due this cycle: 0 none,1 sram,2 oor,3 hit
  int unsigned m_pword[2];
  logic [31:0] m_out[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_att[d] = 0; m_att_tag[d] = 0; m_elapsed[d] = 0;
      m_bv[d] = 0; m_btag[d] = 0; m_pend[d] = 0; m_pword[d] = 0;
      m_out[d] = 32'h0;
    end
  endtask

  task automatic check_dut(input int d);
    int unsigned tag, word, kind;
    bit          oor, hit;
    logic        e_ack, e_re, e_busy;
    logic [31:0] e_instr;
    logic        a_ack, a_re, a_busy;
    logic [31:0] a_instr, a_maddr;
    tag  = 32'(addr) >> 2;
    oor  = (32'(addr) >> (mw[d] + 2)) != 0;
    word = tag & ((32'd1 << mw[d]) - 1);
    if (d == 0) begin
      a_ack = ack0; a_re = re0; a_busy = busy0; a_instr = instr0; a_maddr = 32'(maddr0);
    end else begin
      a_ack = ack1; a_re = re1; a_busy = busy1; a_instr = instr1; a_maddr = 32'(maddr1);
    end

    case (m_pend[d])
      1, 3:    e_instr = memfn(m_pword[d]);
      2:       e_instr = 32'h0;
      default: e_instr = m_out[d];
    endcase
    m_out[d] = e_instr;

    e_busy = m_att[d];
    e_ack  = 0;
    e_re   = 0;
    kind   = 0;
    if (m_att[d]) begin
      if (!cyc || tag != m_att_tag[d]) begin
        m_att[d] = 0;
      end else begin
        m_elapsed[d]++;
        if (m_elapsed[d] == ws[d]) begin
          e_ack = 1; e_re = !oor; kind = oor ? 2 : 1;
          m_att[d] = 0;
        end
      end
    end else if (cyc) begin
      hit = m_bv[d] && (m_btag[d] == tag);
      if (hit || oor || ws[d] == 0) begin
        e_ack = 1;
        e_re  = !hit && !oor;
        kind  = hit ? 3 : (oor ? 2 : 1);
      end else begin
        m_att[d] = 1; m_att_tag[d] = tag; m_elapsed[d] = 0;
      end
    end

    // the response landing this cycle updates the buffer at the coming edge
    if (m_pend[d] == 1) begin
      m_bv[d] = 1; m_btag[d] = m_pword[d];
    end else if (m_pend[d] == 2) begin
      m_bv[d] = 0;
    end
    m_pend[d]  = kind;
    m_pword[d] = word;

    chk($sformatf("d%0d ack", d), 32'(a_ack), 32'(e_ack));
    chk($sformatf("d%0d mem_re", d), 32'(a_re), 32'(e_re));
    chk($sformatf("d%0d busy", d), 32'(a_busy), 32'(e_busy));
    chk($sformatf("d%0d instr", d), a_instr, e_instr);
    if (e_re) chk($sformatf("d%0d mem_addr", d), a_maddr, word);
  endtask

  task automatic step(input logic c, input logic [15:0] a);
    @(posedge clk);
    #1;
    cyc  = c;
    addr = a;
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ack0"}, 32'(ack0), 32'h0);
    chk({tag, " ack1"}, 32'(ack1), 32'h0);
    chk({tag, " busy0"}, 32'(busy0), 32'h0);
    chk({tag, " busy1"}, 32'(busy1), 32'h0);
    chk({tag, " re0"}, 32'(re0), 32'h0);
    chk({tag, " re1"}, 32'(re1), 32'h0);
    chk({tag, " instr0"}, instr0, 32'h0);
    chk({tag, " instr1"}, instr1, 32'h0);
  endtask

  initial begin
    logic [15:0] ra;
    rst_n = 1'b0;
    cyc   = 1'b0;
    addr  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back zero-wait fetches
    step(1, 16'h0000); step(1, 16'h0004); step(1, 16'h0008); step(0, 16'h0);
    // wait-state miss held to completion
    repeat (5) step(1, 16'h0010);
    step(0, 16'h0);
    // fill, then refetch same word at another byte offset
    repeat (5) step(1, 16'h0020);
    step(0, 16'h0); step(0, 16'h0);
    step(1, 16'h0022); step(0, 16'h0);
    // redirect mid-wait
    step(1, 16'h0040);
    repeat (6) step(1, 16'h0080);
    step(0, 16'h0);
    // out-of-range for the small memory, in range for the large one
    repeat (5) step(1, 16'h0100);
    step(0, 16'h0);
    // out of range for both
    step(1, 16'h8000); step(1, 16'h8004); step(0, 16'h0);

    // asynchronous reset in the middle of a wait
    step(1, 16'h0044); step(1, 16'h0044);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1, 16'h0044);
    step(0, 16'h0);

    // randomized traffic with sticky addresses so waits can complete
    ra = 16'h0;
    for (int unsigned i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        case ($urandom_range(0, 3))
          0: ra = 16'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
          1: ra = 16'(16'h0100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
          2: ra = 16'(16'h8000 + 4 * $urandom_range(0, 3));
          default: ra = 16'(4 * $urandom_range(0, 255));
        endcase
      end
      step($urandom_range(0, 9) != 0, ra);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
